// File: rtl/scrypt_dispatch_pkg.sv
// Shared defaults, tag type and width helpers for the scrypt job dispatcher.
// Imported by scrypt_rr_arbiter and scrypt_job_dispatcher.
package scrypt_dispatch_pkg;

  localparam int HDR_W_DEF  = 640;
  localparam int HASH_W_DEF = 256;
  localparam int TAG_W_DEF  = 4;

  typedef logic [TAG_W_DEF-1:0] tag_t;

  // Width of a counter holding 0..n (jobs_in_flight).
  function automatic int jif_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of an index into n cores, never zero.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scrypt_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner.
// Ports: req/advance in; one-hot grant and grant_idx out.
module scrypt_rr_arbiter
  import scrypt_dispatch_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic          found;

  // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && j >= int'(ptr_q)) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && j < int'(ptr_q)) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      if (grant_idx == IW'(N - 1)) ptr_d = '0;
      else                         ptr_d = grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/scrypt_job_dispatcher.sv
// Farms headers out to NUM_CORES scrypt cores and returns tagged hashes.
// Ports: hdr_* in stream, core_* core bus, res_* out stream, status.
// SCRYPT_DISPATCH_INORDER_EN: results in dispatch order, else lowest slot.
module scrypt_job_dispatcher
  import scrypt_dispatch_pkg::*;
#(
  parameter int NUM_CORES = 2,
  parameter int HDR_W     = HDR_W_DEF,
  parameter int HASH_W    = HASH_W_DEF,
  parameter int TAG_W     = TAG_W_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          hdr_valid,
  output logic                          hdr_ready,
  input  logic [HDR_W-1:0]              hdr_data,
  output logic [NUM_CORES-1:0]          core_init,
  output logic [HDR_W-1:0]              core_in,
  input  logic [NUM_CORES-1:0]          core_ready,
  input  logic [NUM_CORES-1:0]          core_valid,
  input  logic [NUM_CORES*HASH_W-1:0]   core_out,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [HASH_W-1:0]             res_hash,
  output logic [TAG_W-1:0]              res_tag,
  output logic [jif_w(NUM_CORES)-1:0]   jobs_in_flight,
  output logic                          err_spurious
);

  localparam int N  = NUM_CORES;
  localparam int JW = jif_w(N);
  localparam int IW = idx_w(N);

  logic [N-1:0]             busy_q, busy_d;
  logic [N-1:0]             full_q, full_d;
  logic [N-1:0]             init_q, init_d;
  logic [N-1:0][HASH_W-1:0] hash_q, hash_d;
  logic [N-1:0][TAG_W-1:0]  stag_q, stag_d;
  logic [N-1:0][TAG_W-1:0]  jtag_q, jtag_d;
  logic [HDR_W-1:0]         cin_q, cin_d;
  logic [TAG_W-1:0]         in_tag_q, in_tag_d;
  logic [JW-1:0]            jif_q, jif_d;
  logic                     err_q, err_d;

  logic [N-1:0]  eligible;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_idx;
  logic          accept;
  logic [N-1:0]  cand;
  logic [N-1:0]  sel_oh;
  logic          found;
  logic          res_hs;

  assign eligible = core_ready & ~busy_q & ~full_q;
  assign hdr_ready = |eligible & ~|init_q;
  assign accept = hdr_valid & hdr_ready;

  scrypt_rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (eligible),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

`ifdef SCRYPT_DISPATCH_INORDER_EN
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  always_comb begin
    for (int k = 0; k < N; k++)
      cand[k] = full_q[k] && (stag_q[k] == out_tag_q);
  end

  always_comb begin
    out_tag_d = out_tag_q;
    if (res_hs) out_tag_d = out_tag_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_tag_q <= '0;
    else          out_tag_q <= out_tag_d;
  end
`else
  assign cand = full_q;
`endif

  // Tags are unique among live jobs, so at most one slot matches
  // in-order; out of order the lowest index wins.
  always_comb begin
    sel_oh = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && cand[k]) begin
        found     = 1'b1;
        sel_oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    res_hash = '0;
    res_tag  = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_oh[k]) begin
        res_hash = res_hash | hash_q[k];
        res_tag  = res_tag | stag_q[k];
      end
    end
  end

  assign res_valid = |sel_oh;
  assign res_hs = res_valid & res_ready;

  always_comb begin
    busy_d   = busy_q;
    full_d   = full_q;
    hash_d   = hash_q;
    stag_d   = stag_q;
    jtag_d   = jtag_q;
    in_tag_d = in_tag_q;
    err_d    = err_q;
    init_d   = '0;
    cin_d    = '0;
    jif_d    = jif_q;
    for (int k = 0; k < N; k++) begin
      if (res_hs && sel_oh[k]) full_d[k] = 1'b0;
      if (core_valid[k]) begin
        if (busy_q[k]) begin
          busy_d[k] = 1'b0;
          full_d[k] = 1'b1;
          hash_d[k] = core_out[k*HASH_W +: HASH_W];
          stag_d[k] = jtag_q[k];
        end else begin
          err_d = 1'b1;
        end
      end
    end
    if (accept) begin
      init_d            = grant;
      cin_d             = hdr_data;
      busy_d            = busy_d | grant;
      jtag_d[grant_idx] = in_tag_q;
      in_tag_d          = in_tag_q + 1'b1;
    end
    unique case ({accept, res_hs})
      2'b10:   jif_d = jif_q + 1'b1;
      2'b01:   jif_d = jif_q - 1'b1;
      default: jif_d = jif_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q   <= '0;
      full_q   <= '0;
      init_q   <= '0;
      hash_q   <= '0;
      stag_q   <= '0;
      jtag_q   <= '0;
      cin_q    <= '0;
      in_tag_q <= '0;
      jif_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      full_q   <= full_d;
      init_q   <= init_d;
      hash_q   <= hash_d;
      stag_q   <= stag_d;
      jtag_q   <= jtag_d;
      cin_q    <= cin_d;
      in_tag_q <= in_tag_d;
      jif_q    <= jif_d;
      err_q    <= err_d;
    end
  end

  assign core_init      = init_q;
  assign core_in        = cin_q;
  assign jobs_in_flight = jif_q;
  assign err_spurious   = err_q;

endmodule
